// File: rtl/bcd_adder_serial_pkg.sv
// bcd_adder_serial_pkg: shared state encoding and seven-segment patterns for the serial BCD adder
package bcd_adder_serial_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bcd_adder_serial_digit.sv
// bcd_digit_add: one-digit BCD add with decimal correction and invalid-digit flag
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       inv
);
    logic [4:0] t;
    assign t   = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    assign co  = t > 5'd9;
    assign s   = co ? t[3:0] + 4'd6 : t[3:0];
    assign inv = (a > 4'd9) || (b > 4'd9);
endmodule

// File: rtl/bcd_adder_serial.sv
// bcd_adder_serial: N-digit packed-BCD adder, one digit per clock LSD first,
// with sticky invalid-digit error and active-low seven-segment outputs.
module bcd_adder_serial
    import bcd_adder_serial_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  error,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int IDXW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int W    = 4 * DIGITS;

    state_t          state, state_n;
    logic [W-1:0]    xs, ys, acc, acc_n;
    logic [IDXW-1:0] idx;
    logic            carry, serr, last, dco, dinv, err_n;
    logic [3:0]      dsum;

    assign last  = idx == IDXW'(DIGITS - 1);
    assign err_n = serr | dinv;

    bcd_digit_add u_digit (
        .a  (xs[idx*4 +: 4]),
        .b  (ys[idx*4 +: 4]),
        .ci (carry),
        .s  (dsum),
        .co (dco),
        .inv(dinv)
    );

    always_comb begin
        acc_n = acc;
        acc_n[idx*4 +: 4] = dsum;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        busy    = state != IDLE;
        done    = state == DONE;
        state_n = state == IDLE ? (start ? ADD : IDLE) :
                  state == ADD  ? (last ? DONE : ADD) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            serr  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            error <= 1'b0;
        end else if (state == IDLE && start) begin
            xs    <= x;
            ys    <= y;
            carry <= cin;
            acc   <= '0;
            idx   <= '0;
            serr  <= 1'b0;
        end else if (state == ADD) begin
            acc   <= acc_n;
            carry <= dco;
            serr  <= err_n;
            idx   <= last ? idx : idx + 1'b1;
            // output registers only move on the edge entering DONE
            if (last) begin
                sum   <= err_n ? '0 : acc_n;
                cout  <= !err_n && dco;
                error <= err_n;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign seg[7*i +: 7] = error ? SEG_DASH : seg_decode(sum[4*i +: 4]);
    end
endmodule

// File: tb/tb_bcd_adder_serial.sv
// tb_bcd_adder_serial: table-driven and directed checks of the serial BCD adder
module tb_bcd_adder_serial;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic        start2 = 0, cin2 = 0, busy2, done2, cout2, err2;
    logic [7:0]  x2 = 0, y2 = 0, sum2;
    logic [13:0] seg2;
    logic        start4 = 0, cin4 = 0, busy4, done4, cout4, err4;
    logic [15:0] x4 = 0, y4 = 0, sum4;
    logic [27:0] seg4;
    logic        start1 = 0, cin1 = 0, busy1, done1, cout1, err1;
    logic [3:0]  x1 = 0, y1 = 0, sum1;
    logic [6:0]  seg1;

    bcd_adder_serial #(.DIGITS(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .y(y2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .error(err2), .seg(seg2));
    bcd_adder_serial #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .error(err4), .seg(seg4));
    bcd_adder_serial #(.DIGITS(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .y(y1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .error(err1), .seg(seg1));

    typedef struct {
        logic [7:0]  x, y;
        logic        cin;
        logic [7:0]  s;
        logic        co, err;
        logic [13:0] seg;
    } vec_t;

    vec_t v[10];
    int   passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int edges, output int busyc);
        @(negedge clk);
        x2 = a; y2 = b; cin2 = c; start2 = 1;
        @(negedge clk);
        start2 = 0;
        edges = 1;
        busyc = int'(busy2);
        while (!done2 && edges < 20) begin
            @(negedge clk);
            edges++;
            busyc += int'(busy2);
        end
    endtask

    initial begin
        int e, b, n;
        logic [7:0] cap;
        v[0] = '{8'h47, 8'h38, 1'b0, 8'h85, 1'b0, 1'b0, {7'b0000000, 7'b0010010}};
        v[1] = '{8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0, {7'b0010000, 7'b0010000}};
        v[2] = '{8'h3A, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, {7'b0111111, 7'b0111111}};
        v[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, {7'b0011001, 7'b0000010}};
        v[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, {7'b1000000, 7'b1000000}};
        v[5] = '{8'hA3, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, {7'b0111111, 7'b0111111}};
        v[6] = '{8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0, {7'b1000000, 7'b1000000}};
        v[7] = '{8'h09, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, {7'b1111001, 7'b1000000}};
        v[8] = '{8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, {7'b1000000, 7'b1000000}};
        v[9] = '{8'h27, 8'h65, 1'b0, 8'h92, 1'b0, 1'b0, {7'b0010000, 7'b0100100}};

        #1;
        chk("rst_sum", 32'(sum2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_done", 32'(done2), 0);
        chk("rst_cout_err", 32'({cout2, err2}), 0);
        chk("rst_seg", 32'(seg2), 32'({7'b1000000, 7'b1000000}));
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            run2(v[i].x, v[i].y, v[i].cin, e, b);
            chk($sformatf("v%0d_latency", i), 32'(e), 3);
            chk($sformatf("v%0d_busy", i), 32'(b), 3);
            chk($sformatf("v%0d_sum", i), 32'(sum2), 32'(v[i].s));
            chk($sformatf("v%0d_cout", i), 32'(cout2), 32'(v[i].co));
            chk($sformatf("v%0d_err", i), 32'(err2), 32'(v[i].err));
            chk($sformatf("v%0d_seg", i), 32'(seg2), 32'(v[i].seg));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done2), 0);
        end

        // start held high through ADD/DONE with changing operands must be ignored
        @(negedge clk);
        x2 = 8'h12; y2 = 8'h34; cin2 = 0; start2 = 1;
        n = 0; cap = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done2) begin n++; cap = sum2; end
            else if (!busy2) start2 = 0;
            x2 = 8'h99; y2 = 8'h99; cin2 = 1;
        end
        chk("ign_done_count", 32'(n), 1);
        chk("ign_sum", 32'(cap), 32'h46);

        // reset while ADD idx=1 aborts the operation
        @(negedge clk);
        x2 = 8'h11; y2 = 8'h22; cin2 = 0; start2 = 1;
        @(negedge clk);
        start2 = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort_sum", 32'(sum2), 0);
        chk("abort_busy", 32'(busy2), 0);
        chk("abort_seg", 32'(seg2), 32'({7'b1000000, 7'b1000000}));
        @(negedge clk);
        rst_n = 1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n += int'(done2);
        end
        chk("abort_no_done", 32'(n), 0);
        run2(8'h55, 8'h44, 1'b0, e, b);
        chk("after_abort_sum", 32'(sum2), 32'h99);
        chk("after_abort_latency", 32'(e), 3);

        // four digits: full carry ripple
        @(negedge clk);
        x4 = 16'h9999; y4 = 16'h0001; cin4 = 0; start4 = 1;
        @(negedge clk);
        start4 = 0; e = 1;
        while (!done4 && e < 20) begin @(negedge clk); e++; end
        chk("d4_latency", 32'(e), 5);
        chk("d4_sum", 32'(sum4), 0);
        chk("d4_cout", 32'(cout4), 1);
        chk("d4_err", 32'(err4), 0);

        // one digit: single ADD cycle
        @(negedge clk);
        x1 = 4'd5; y1 = 4'd4; cin1 = 1; start1 = 1;
        @(negedge clk);
        start1 = 0; e = 1;
        while (!done1 && e < 20) begin @(negedge clk); e++; end
        chk("d1_latency", 32'(e), 2);
        chk("d1_sum", 32'(sum1), 0);
        chk("d1_cout", 32'(cout1), 1);
        chk("d1_seg", 32'(seg1), 32'(7'b1000000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
